// File: rtl/stepper_controller_top.sv
// -----------------------------------------------------------------------------
// stepper_controller_top
//
// Four-phase stepper motor controller for a ULN2003-style driver. Three level
// buttons (run/stop, direction, speed) are synchronized and debounced. The
// accepted levels control a step timer that advances an 8-state half-step
// phase index. Coil drive and status LEDs are all registered.
//
// Parameters:
//   DIV_SLOW  clock cycles per half-step when speed is slow
//   DIV_FAST  clock cycles per half-step when speed is fast (2 <= DIV_FAST < DIV_SLOW)
//   DEBOUNCE  cycles a synchronized button level must differ before acceptance (>= 1)
//
// Ports:
//   clk                    system clock
//   rst_n                  asynchronous active-low reset
//   btn_start_stop         1 = run, 0 = stop
//   btn_direction_control  0 = forward, 1 = reverse
//   btn_speed              0 = slow, 1 = fast
//   in1..in4               coil drive, active-high
//   led                    running indicator, active-low
//   led1                   direction indicator, active-low (lit = reverse)
//   led2                   speed indicator, active-low (lit = fast)
//   led3                   heartbeat, toggles on every step
// -----------------------------------------------------------------------------
module stepper_controller_top #(
    parameter int DIV_SLOW = 100000,
    parameter int DIV_FAST = 50000,
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_start_stop,
    input  logic btn_direction_control,
    input  logic btn_speed,
    output logic in1,
    output logic in2,
    output logic in3,
    output logic in4,
    output logic led,
    output logic led1,
    output logic led2,
    output logic led3
);

    // Debounce counter only needs to hold 0..DEBOUNCE-1: acceptance happens on
    // the increment that would bring it to DEBOUNCE.
    localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
    localparam int TW = $clog2(DIV_SLOW);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] SLOW_LAST = TW'(DIV_SLOW - 1);
    localparam logic [TW-1:0] FAST_LAST = TW'(DIV_FAST - 1);

    // Bit 0 = run/stop, bit 1 = direction, bit 2 = speed
    logic [2:0] btn_raw;
    logic [2:0] accepted;

    assign btn_raw = {btn_speed, btn_direction_control, btn_start_stop};

    // -------------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizer followed by a hold-count filter
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_button
            logic          sync1_reg;
            logic          sync2_reg;
            logic          acc_reg;
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    acc_reg   <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == acc_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        acc_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end

            assign accepted[gi] = acc_reg;
        end
    endgenerate

    logic run;
    logic dir;
    logic fast;

    assign run  = accepted[0];
    assign dir  = accepted[1];
    assign fast = accepted[2];

    // -------------------------------------------------------------------------
    // Step timer and phase index
    // -------------------------------------------------------------------------
    logic [TW-1:0] timer_reg;
    logic [TW-1:0] timer_next;
    logic [TW-1:0] div_last;
    logic [2:0]    phase_reg;
    logic [2:0]    phase_next;
    logic          step;

    always_comb begin
        div_last   = fast ? FAST_LAST : SLOW_LAST;
        // ">=" so a slow-to-fast switch past the fast terminal steps at once
        step       = run && (timer_reg >= div_last);
        timer_next = timer_reg + TW'(1);
        if (!run || step) begin
            timer_next = '0;
        end
        phase_next = phase_reg;
        if (step) begin
            phase_next = dir ? (phase_reg - 3'd1) : (phase_reg + 3'd1);
        end
    end

    // Half-step coil pattern {in1, in2, in3, in4}
    function automatic logic [3:0] coil_pattern(input logic [2:0] phase);
        logic [3:0] pattern;
        case (phase)
            3'd0:    pattern = 4'b1000;
            3'd1:    pattern = 4'b1100;
            3'd2:    pattern = 4'b0100;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0010;
            3'd5:    pattern = 4'b0011;
            3'd6:    pattern = 4'b0001;
            default: pattern = 4'b1001;
        endcase
        return pattern;
    endfunction

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    logic [3:0] coil_reg;
    logic       led_reg;
    logic       led1_reg;
    logic       led2_reg;
    logic       led3_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg <= '0;
            phase_reg <= 3'd0;
            coil_reg  <= 4'b0000;
            led_reg   <= 1'b1;
            led1_reg  <= 1'b1;
            led2_reg  <= 1'b1;
            led3_reg  <= 1'b1;
        end else begin
            timer_reg <= timer_next;
            phase_reg <= phase_next;
            // Coils follow the post-step phase so a step is visible the cycle
            // after the terminal count; stopping de-energizes them.
            coil_reg  <= run ? coil_pattern(phase_next) : 4'b0000;
            led_reg   <= ~run;
            led1_reg  <= ~dir;
            led2_reg  <= ~fast;
            if (step) begin
                led3_reg <= ~led3_reg;
            end
        end
    end

    assign {in1, in2, in3, in4} = coil_reg;
    assign led  = led_reg;
    assign led1 = led1_reg;
    assign led2 = led2_reg;
    assign led3 = led3_reg;

endmodule

// File: tb/tb_stepper_controller_top.sv
// -----------------------------------------------------------------------------
// tb_stepper_controller_top
//
// Directed bench for stepper_controller_top with small dividers. Expected
// coil/LED states are pushed to a scoreboard with the absolute cycle at which
// they must appear; the drain task pops and compares them at that cycle.
// Cycle offsets are relative to t0, the clock edge where run is accepted.
// -----------------------------------------------------------------------------
module tb_stepper_controller_top;

    localparam int DIV_SLOW = 20;
    localparam int DIV_FAST = 8;
    localparam int DEBOUNCE = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic b_run = 1'b0;
    logic b_dir = 1'b0;
    logic b_fast = 1'b0;
    logic in1, in2, in3, in4, led, led1, led2, led3;
    logic [3:0] coils;
    logic [3:0] leds;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int t0 = 0;
    int c0;

    typedef struct {
        int         at;
        logic [3:0] coils;
        logic [3:0] leds;
    } exp_t;

    exp_t sb[$];

    stepper_controller_top #(
        .DIV_SLOW(DIV_SLOW),
        .DIV_FAST(DIV_FAST),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .btn_start_stop       (b_run),
        .btn_direction_control(b_dir),
        .btn_speed            (b_fast),
        .in1                  (in1),
        .in2                  (in2),
        .in3                  (in3),
        .in4                  (in4),
        .led                  (led),
        .led1                 (led1),
        .led2                 (led2),
        .led3                 (led3)
    );

    assign coils = {in1, in2, in3, in4};
    assign leds  = {led, led1, led2, led3};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check4(input string name, input int rel, input logic [3:0] obs,
                          input logic [3:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s t+%0d: got %b expected %b", name, rel, obs, expv);
        end
        $display("[TB] %s t+%0d: got %b expected %b", name, rel, obs, expv);
    endtask

    task automatic push(input int rel, input logic [3:0] c, input logic [3:0] l);
        exp_t e;
        e.at    = t0 + rel;
        e.coils = c;
        e.leds  = l;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_until(e.at);
            if (cyc != e.at) begin
                tests++;
                fails++;
                $error("FAIL schedule t+%0d: reached cycle %0d expected %0d",
                       e.at - t0, cyc, e.at);
            end else begin
                check4("coils", e.at - t0, coils, e.coils);
                check4("leds", e.at - t0, leds, e.leds);
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then release with all buttons low
        repeat (3) @(negedge clk);
        check4("reset_coils", 0, coils, 4'b0000);
        check4("reset_leds", 0, leds, 4'b1111);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check4("idle_coils", 0, coils, 4'b0000);
        check4("idle_leds", 0, leds, 4'b1111);

        // Forward slow run: accepted at c0 + DEBOUNCE + 2, outputs one cycle later
        c0 = cyc + 1;
        wait_until(c0);
        b_run = 1'b1;
        t0 = c0 + DEBOUNCE + 2;
        push(0,   4'b0000, 4'b1111);
        push(1,   4'b1000, 4'b0111);
        push(19,  4'b1000, 4'b0111);
        push(20,  4'b1100, 4'b0110);
        push(40,  4'b0100, 4'b0111);
        push(60,  4'b0110, 4'b0110);
        drain();

        // Reverse: led1 lights, index decrements and wraps 0 -> 7
        wait_until(t0 + 61);
        b_dir = 1'b1;
        push(67,  4'b0110, 4'b0110);
        push(68,  4'b0110, 4'b0010);
        push(80,  4'b0100, 4'b0011);
        push(100, 4'b1100, 4'b0010);
        push(120, 4'b1000, 4'b0011);
        push(139, 4'b1000, 4'b0011);
        push(140, 4'b1001, 4'b0010);
        drain();

        // Fast accepted with timer already past DIV_FAST-1: immediate step
        wait_until(t0 + 146);
        b_fast = 1'b1;
        push(152, 4'b1001, 4'b0010);
        push(153, 4'b0001, 4'b0001);
        push(160, 4'b0001, 4'b0001);
        push(161, 4'b0011, 4'b0000);
        push(169, 4'b0010, 4'b0001);
        drain();

        // Stop lands on a terminal-count cycle: step suppressed, coils off
        wait_until(t0 + 170);
        b_run = 1'b0;
        push(176, 4'b0010, 4'b0001);
        push(177, 4'b0000, 4'b1001);
        push(180, 4'b0000, 4'b1001);
        drain();

        // Resume: held phase reappears, first step a full DIV_FAST later
        wait_until(t0 + 190);
        b_run = 1'b1;
        push(196, 4'b0000, 4'b1001);
        push(197, 4'b0010, 4'b0001);
        push(203, 4'b0010, 4'b0001);
        push(204, 4'b0110, 4'b0000);
        drain();

        // Direction glitch of DEBOUNCE-1 cycles: ignored
        wait_until(t0 + 205);
        b_dir = 1'b0;
        wait_until(t0 + 208);
        b_dir = 1'b1;
        push(210, 4'b0110, 4'b0000);
        push(212, 4'b0100, 4'b0001);
        push(220, 4'b1100, 4'b0000);
        drain();

        // Direction held DEBOUNCE cycles: accepted, forward from next step
        wait_until(t0 + 221);
        b_dir = 1'b0;
        push(227, 4'b1100, 4'b0000);
        push(228, 4'b0100, 4'b0101);
        drain();

        // Asynchronous reset mid-run, between clock edges
        wait_until(t0 + 235);
        #2;
        rst_n = 1'b0;
        #1;
        check4("async_reset_coils", 235, coils, 4'b0000);
        check4("async_reset_leds", 235, leds, 4'b1111);
        b_run  = 1'b0;
        b_dir  = 1'b0;
        b_fast = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (DEBOUNCE + 6) @(negedge clk);
        check4("after_reset_coils", 0, coils, 4'b0000);
        check4("after_reset_leds", 0, leds, 4'b1111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
